dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-port arbiter and access sequencer in front of the single-ported MIPS data memory. Shares the memory between the CPU load/store port (p0) and a debug/DMA port (p1). Converts each granted request into a one-cycle MemRead/MemWrite strobe with a word address. Returns read data, or a write/error completion, through a registered valid pulse.

## Interface
Parameters:
- ADDR_W, 8: word-index width; the memory holds 2^ADDR_W 32-bit words.
- MEM_LAT, 1: cycles from the mem_read strobe to valid mem_rdata. Legal range is 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pN_req  in  1  request for N = 0, 1; held until pN_gnt.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  write data.
- pN_gnt  out  1  one-cycle pulse; the request has been accepted.
- pN_rvalid  out  1  one-cycle completion pulse.
- pN_rdata  out  32  read data, valid only with pN_rvalid; 0 for writes and errors.
- pN_err  out  1  qualifies pN_rvalid; marks a misaligned or out-of-range access.
- mem_addr  out  32  word index {0, addr[ADDR_W+1:2]}.
- mem_wdata  out  32  write data to memory.
- mem_read  out  1  read strobe to memory.
- mem_write  out  1  write strobe to memory.
- mem_rdata  in  32  data from memory.

## Operation
- State machine states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - Samples p0_req and p1_req.
  - If either is high, latches the winner's we, addr and wdata and the winner's id, then goes to ISSUE.
- **ISSUE** (exactly one cycle)
  - Pulses the winner's gnt.
  - If the access is legal, drives mem_addr and mem_wdata and pulses mem_write (we = 1) or mem_read (we = 0).
  - Legal means addr[1:0] == 0 and addr[31:ADDR_W+2] == 0.
  - Next state is RESP for a write or an illegal access, and WAIT for a legal read.
- **WAIT**
  - Counts MEM_LAT cycles.
  - In the last cycle, registers mem_rdata into the winner's rdata holding register, then goes to RESP.
- **RESP** (exactly one cycle)
  - Pulses the winner's rvalid.
  - rdata is the captured value for a read and 0 otherwise.
  - err = 1 for an illegal access; an illegal access never strobes memory.
  - Goes to IDLE.
- Arbitration happens only in IDLE.
  - A requester must deassert req no later than the cycle its gnt is high.
  - A req still high in IDLE is treated as a new request.
- The losing requester keeps req high and is served on a later IDLE.
- mem_read and mem_write are never high together.
- Outside ISSUE: mem_read = mem_write = 0, and mem_addr and mem_wdata hold their last value.
- Reset (rst low, at any time, including mid-transaction):
  - All outputs go to 0 immediately, the state goes to IDLE, and the round-robin pointer goes to "p0 preferred".
  - An in-flight transaction is dropped with no rvalid.

## Timing
- Request sampled high in IDLE at cycle 0 → gnt and strobe in cycle 1.
- Write completion: rvalid in cycle 2.
- Read completion: rvalid in cycle 2 + MEM_LAT (cycle 3 at default).
- Error completion: rvalid in cycle 2.
- Earliest next grant is 2 cycles after rvalid: IDLE is in cycle rvalid + 1, ISSUE in cycle rvalid + 2.
- Throughput: one access per 3 cycles for writes, per 3 + MEM_LAT cycles for reads.
- No combinational path exists from any input to any output; all outputs are registered.

## Configuration
- Macro: DMEM_ARB_RR_EN.
- **Defined (round-robin):**
  - A 1-bit pointer records the last granted port.
  - On a simultaneous request, the port not granted last wins.
  - A lone requester always wins.
  - The pointer updates in ISSUE.
- **Undefined (fixed priority):** p0 always wins a simultaneous request, and the pointer logic is absent.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to byte address 0x10 → cycle 1 has mem_write = 1 and mem_addr = 4; cycle 2 has p0_rvalid = 1, p0_err = 0, p0_rdata = 0.
- p1 reads 0x10 with mem_rdata driven to 0xDEADBEEF → mem_read pulses in cycle 1; p1_rvalid = 1 with p1_rdata = 0xDEADBEEF in cycle 3.
- p0_req and p1_req both high from cycle 0 → fixed priority: p0 gnt in cycle 1, p1 gnt in cycle 5. Round-robin: the next tie after a p0 grant goes to p1.
- p0 reads address 0x402 and then address 0x400 (ADDR_W = 8) → no mem strobe for either; p0_rvalid = 1 and p0_err = 1 in cycle 2 of each access.
- rst pulled low during WAIT of a p0 read → all outputs 0 at once; after release, no p0_rvalid appears and a fresh p1 request is granted 1 cycle after being sampled.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported MIPS data memory.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking (fixed p0 priority otherwise).
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic               id_q, id_d;
  logic               we_q, we_d;
  logic               legal_q, legal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         rvalid_q, rvalid_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
`ifdef DMEM_ARB_RR_EN
  logic               pref_q, pref_d;
`endif

  logic               win_id;
  logic               win_we;
  logic [31:0]        win_addr;
  logic [31:0]        win_wdata;
  logic               win_legal;

  // Winner selection among the ports currently requesting
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    win_id = (p0_req && p1_req) ? pref_q : !p0_req;
`else
    win_id = !p0_req;
`endif
    win_we    = win_id ? p1_we    : p0_we;
    win_addr  = win_id ? p1_addr  : p0_addr;
    win_wdata = win_id ? p1_wdata : p0_wdata;
    win_legal = (win_addr[1:0] == 2'b00) && ((win_addr >> (ADDR_W + 2)) == 32'd0);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    legal_d     = legal_q;
    cnt_d       = cnt_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    err_d       = 2'b00;
    rdata0_d    = 32'd0;
    rdata1_d    = 32'd0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
    pref_d      = pref_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          id_d          = win_id;
          we_d          = win_we;
          legal_d       = win_legal;
          gnt_d[win_id] = 1'b1;
          if (win_legal) begin
            mem_addr_d  = 32'(win_addr[ADDR_W+1:2]);
            mem_wdata_d = win_wdata;
            mem_read_d  = !win_we;
            mem_write_d = win_we;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef DMEM_ARB_RR_EN
        pref_d = !id_q;
`endif
        if (we_q || !legal_q) begin
          rvalid_d[id_q] = 1'b1;
          err_d[id_q]    = !legal_q;
          state_d        = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rvalid_d[id_q] = 1'b1;
          if (id_q) rdata1_d = mem_rdata;
          else      rdata0_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      legal_q     <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      pref_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      legal_q     <= legal_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
`ifdef DMEM_ARB_RR_EN
      pref_q      <= pref_d;
`endif
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: memory emulator plus a transaction-level
// reference model predicting grant order, completion cycles, data and error flags.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEM_LAT = 1;
  localparam int          BUDGET  = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  rd_pending;
  int          lat_cnt = 0;
  bit          model_pref = 1'b0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Memory emulator: data becomes valid MEM_LAT cycles after the read strobe cycle
  always @(negedge clk) begin
    if (mem_write) tb_mem[mem_addr[7:0]] = mem_wdata;
    if (mem_read) begin
      if (MEM_LAT == 1) mem_rdata = tb_mem[mem_addr[7:0]];
      else begin
        mem_rdata  = 32'hBAD0_BAD0;
        rd_pending = mem_addr[7:0];
        lat_cnt    = int'(MEM_LAT) - 1;
      end
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) mem_rdata = tb_mem[rd_pending];
    end
  end

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd4 << ADDR_W));
  endfunction

  function automatic logic [191:0] all_outs();
    return {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_read, mem_write,
            p0_rdata, p1_rdata, mem_addr, mem_wdata, 56'd0};
  endfunction

  // Issue requests on one or both ports in the current (idle) cycle and check every event
  task automatic run_pair(input string name, input bit r0, input bit r1,
                          input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    int egnt[2], erv[2], ggnt[2], grv[2], ngnt[2];
    logic [31:0] erd[2], grd[2], gsa[2], gsd[2], ad[2], wd[2];
    bit eerr[2], gerr[2], gsr[2], gsw[2], lg[2], wev[2], want[2];
    int order[$];
    int t, p, stray, both_strb;
    bit done;
    ad = '{a0, a1}; wd = '{d0, d1}; wev = '{bit'(we0), bit'(we1)}; want = '{r0, r1};
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      p = model_pref ? 1 : 0;
`else
      p = 0;
`endif
      order.push_back(p);
      order.push_back(1 - p);
    end else if (r0) order.push_back(0);
    else order.push_back(1);
    t = 0;
    foreach (order[i]) begin
      p       = order[i];
      lg[p]   = is_legal(ad[p]);
      egnt[p] = t + 1;
      erv[p]  = t + 2 + ((lg[p] && !wev[p]) ? int'(MEM_LAT) : 0);
      erd[p]  = (lg[p] && !wev[p]) ? ref_mem[int'(ad[p] / 4)] : 32'd0;
      if (lg[p] && wev[p]) ref_mem[int'(ad[p] / 4)] = wd[p];
      eerr[p] = !lg[p];
      model_pref = (p == 0);
      t = erv[p] + 1;
    end
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    ggnt = '{-1, -1}; grv = '{-1, -1}; ngnt = '{0, 0};
    grd = '{32'd0, 32'd0}; gsa = '{32'd0, 32'd0}; gsd = '{32'd0, 32'd0};
    gerr = '{1'b0, 1'b0}; gsr = '{1'b0, 1'b0}; gsw = '{1'b0, 1'b0};
    stray = 0; both_strb = 0; done = 1'b0;
    for (int k = 1; k <= BUDGET && !done; k++) begin
      @(negedge clk);
      if (mem_read && mem_write) both_strb++;
      if ((mem_read || mem_write) && !p0_gnt && !p1_gnt) stray++;
      if (p0_gnt) begin
        ngnt[0]++; ggnt[0] = k; gsr[0] = mem_read; gsw[0] = mem_write;
        gsa[0] = mem_addr; gsd[0] = mem_wdata; p0_req = 1'b0;
      end
      if (p1_gnt) begin
        ngnt[1]++; ggnt[1] = k; gsr[1] = mem_read; gsw[1] = mem_write;
        gsa[1] = mem_addr; gsd[1] = mem_wdata; p1_req = 1'b0;
      end
      if (p0_rvalid) begin grv[0] = k; grd[0] = p0_rdata; gerr[0] = p0_err; end
      if (p1_rvalid) begin grv[1] = k; grd[1] = p1_rdata; gerr[1] = p1_err; end
      done = (!want[0] || grv[0] >= 0) && (!want[1] || grv[1] >= 0);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: completion not seen within %0d cycles", name, BUDGET);
    end
    @(negedge clk);
    for (int q = 0; q < 2; q++) begin
      if (!want[q]) begin
        checks++;
        if (ngnt[q] != 0 || grv[q] != -1) begin
          failures++;
          $display("FAIL %s p%0d idle: gnts=%0d rvalid_cycle=%0d expected none", name, q, ngnt[q], grv[q]);
        end
        continue;
      end
      checks++;
      if (ggnt[q] != egnt[q] || ngnt[q] != 1) begin
        failures++;
        $display("FAIL %s p%0d gnt: cycle=%0d count=%0d expected cycle=%0d count=1", name, q, ggnt[q], ngnt[q], egnt[q]);
      end
      checks++;
      if (grv[q] != erv[q]) begin
        failures++;
        $display("FAIL %s p%0d rvalid cycle: got %0d expected %0d", name, q, grv[q], erv[q]);
      end
      checks++;
      if (grd[q] !== erd[q] || gerr[q] !== eerr[q]) begin
        failures++;
        $display("FAIL %s p%0d resp: rdata=%h err=%0b expected rdata=%h err=%0b", name, q, grd[q], gerr[q], erd[q], eerr[q]);
      end
      checks++;
      if (gsr[q] !== (lg[q] && !wev[q]) || gsw[q] !== (lg[q] && wev[q])) begin
        failures++;
        $display("FAIL %s p%0d strobe: read=%0b write=%0b expected read=%0b write=%0b", name, q, gsr[q], gsw[q], lg[q] && !wev[q], lg[q] && wev[q]);
      end
      if (lg[q]) begin
        checks++;
        if (gsa[q] !== ad[q] / 4 || (wev[q] && gsd[q] !== wd[q])) begin
          failures++;
          $display("FAIL %s p%0d mem bus: addr=%h wdata=%h expected addr=%h wdata=%h", name, q, gsa[q], gsd[q], ad[q] / 4, wd[q]);
        end
      end
    end
    checks++;
    if (stray != 0 || both_strb != 0) begin
      failures++;
      $display("FAIL %s strobes: stray=%0d both_high=%0d expected 0 and 0", name, stray, both_strb);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_hold: outputs=%h expected 0", all_outs());
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_idle: outputs=%h expected 0", all_outs());
    end
  endtask

  task automatic test_write();
    run_pair("p0_write", 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_read();
    run_pair("p1_read", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10, 32'h0);
    checks++;
    if (ref_mem[4] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ref_word4: got %h expected deadbeef", ref_mem[4]);
    end
  endtask

  task automatic test_tie();
    run_pair("tie_a", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h20, 32'h1234_5678);
    run_pair("tie_b", 1'b1, 1'b1, 1'b1, 32'h24, 32'hA5A5_0001, 1'b0, 32'h20, 32'h0);
    run_pair("tie_c", 1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_errors();
    run_pair("err_misaligned", 1'b1, 1'b0, 1'b0, 32'h402, 32'h0, 1'b0, 32'h0, 32'h0);
    run_pair("err_range", 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, 32'h0);
    run_pair("err_write_top", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_pair("edge_last_word", 1'b1, 1'b0, 1'b1, 32'h3FC, 32'h0BAD_CAFE, 1'b0, 32'h0, 32'h0);
  endtask

  // A request raised in the rvalid cycle of the previous access is granted two cycles later
  task automatic test_back_to_back();
    int r, g, k;
    ref_mem[8] = 32'h7777_0008;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h7777_0008;
    r = -1; g = -1; k = 0;
    while (g < 0 && k < BUDGET) begin
      @(negedge clk); k++;
      if (p0_gnt) p0_req = 1'b0;
      if (p0_rvalid) begin
        r = k;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
      end
      if (p1_gnt) begin g = k; p1_req = 1'b0; end
    end
    checks++;
    if (r < 0 || g != r + 2) begin
      failures++;
      $display("FAIL b2b_gap: rvalid=%0d next_gnt=%0d expected next_gnt=rvalid+2", r, g);
    end
    k = 0;
    while (!p1_rvalid && k < BUDGET) begin @(negedge clk); k++; end
    checks++;
    if (!p1_rvalid || p1_rdata !== 32'h7777_0008) begin
      failures++;
      $display("FAIL b2b_read: rvalid=%0b rdata=%h expected 1 and 77770008", p1_rvalid, p1_rdata);
    end
    p1_req = 1'b0;
    @(negedge clk);
    model_pref = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h3C;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || mem_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt: gnt=%0b mem_read=%0b expected 1 1", p0_gnt, mem_read);
    end
    p0_req = 1'b0;
    repeat (MEM_LAT) @(negedge clk);
    checks++;
    if (mem_addr !== 32'd15 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold: mem_addr=%h mem_read=%0b expected f 0", mem_addr, mem_read);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL mid_reset_async: outputs=%h expected 0", all_outs());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_pref = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid || p0_gnt || p1_gnt) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_dropped: stray pulses=%0d expected 0", seen);
    end
    run_pair("post_reset_p1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 15)) * 4;
    if (sel == 7) a = a + 32'($urandom_range(1, 3));
    else if (sel > 7) a = a | (32'd1 << $urandom_range(10, 31));
    return a;
  endfunction

  task automatic test_random();
    int pat;
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(1, 3);
      run_pair($sformatf("rnd%0d", it), bit'(pat & 1), bit'((pat >> 1) & 1),
               1'($urandom_range(0, 1)), rand_addr(), $urandom,
               1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
